// File: rtl/seq_det_pkg.sv
// Shared definitions for the bit-serial sequence detector family:
// shifter state encoding, the common bit type and the default word width.
package seq_det_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  typedef logic bit_t;

  localparam int SEQ_DET_WIDTH = 8;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bundle of the serializer; master is the upstream/consumer
// side, slave is the serializer itself.
interface seq_bit_serializer_if
  import seq_det_pkg::*;
#(
  parameter int WIDTH = SEQ_DET_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_en;
  bit_t             dout;
  logic             dout_valid;
  logic             busy;
  logic             gap;

  modport master (
    output in_data,
    output in_valid,
    output ser_en,
    input  in_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  gap
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  ser_en,
    output in_ready,
    output dout,
    output dout_valid,
    output busy,
    output gap
  );

endinterface

// File: rtl/seq_hold_reg.sv
// One-word holding register with full flag. A push is taken only while empty,
// so a push and a pop can never collide.
module seq_hold_reg
  import seq_det_pkg::*;
#(
  parameter int WIDTH = SEQ_DET_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;
  logic             w_take;

  assign w_take = i_push && !r_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (w_take) begin
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_take) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: buffers one word and streams words out one
// bit per enabled cycle, contiguously, flagging the end of each burst with gap.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int   WIDTH     = SEQ_DET_WIDTH,
  parameter int   MSB_FIRST = 1,
  parameter bit_t IDLE_BIT  = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  seq_bit_serializer_if.slave bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] w_holdData;
  logic             w_holdFull;
  logic             w_push;
  logic             w_pop;

  ser_state_t       r_state;
  ser_state_t       w_stateNext;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_shNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  bit_t             r_dout;
  bit_t             w_doutNext;
  logic             r_doutValid;
  logic             w_doutValidNext;
  logic             r_gap;
  logic             w_gapNext;

  assign w_push = bus.in_valid && !w_holdFull;

  seq_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (bus.in_data),
    .i_pop  (w_pop),
    .o_data (w_holdData),
    .o_full (w_holdFull)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_gap       <= 1'b0;
      r_dout      <= IDLE_BIT;
      r_doutValid <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_sh        <= w_shNext;
      r_cnt       <= w_cntNext;
      r_gap       <= w_gapNext;
      r_dout      <= w_doutNext;
      r_doutValid <= w_doutValidNext;
    end
  end

  // The serial outputs are precomputed from next state so dout is a bare flop.
  always_comb begin
    w_stateNext = r_state;
    w_shNext    = r_sh;
    w_cntNext   = r_cnt;
    w_pop       = 1'b0;
    w_gapNext   = 1'b0;

    if (bus.ser_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_holdFull) begin
            w_shNext    = w_holdData;
            w_cntNext   = '0;
            w_pop       = 1'b1;
            w_stateNext = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt != CNT_LAST) begin
            w_shNext  = (MSB_FIRST != 0) ? {r_sh[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_sh[WIDTH-1:1]};
            w_cntNext = r_cnt + 1'b1;
          end else if (w_holdFull) begin
            w_shNext  = w_holdData;
            w_cntNext = '0;
            w_pop     = 1'b1;
          end else begin
            w_stateNext = S_IDLE;
            w_gapNext   = 1'b1;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end

    w_doutValidNext = (w_stateNext == S_SHIFT);
    if (w_doutValidNext) begin
      w_doutNext = (MSB_FIRST != 0) ? w_shNext[WIDTH-1] : w_shNext[0];
    end else begin
      w_doutNext = IDLE_BIT;
    end
  end

  assign bus.in_ready   = !w_holdFull;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_doutValid;
  assign bus.gap        = r_gap;
  assign bus.busy       = (r_state == S_SHIFT) || w_holdFull;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first/idle-0 and an LSB-first/idle-1
// instance share one stimulus stream and one word-level reference model.
module tb_seq_bit_serializer;
  import seq_det_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] inData;
  logic         inValid;
  logic         serEn;
  int           enMode;
  int           reqKind;
  int           reqSeq;

  seq_bit_serializer_if #(.WIDTH(W)) ifA ();
  seq_bit_serializer_if #(.WIDTH(W)) ifB ();

  assign ifA.in_data  = inData;
  assign ifA.in_valid = inValid;
  assign ifA.ser_en   = serEn;
  assign ifB.in_data  = inData;
  assign ifB.in_valid = inValid;
  assign ifB.ser_en   = serEn;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted words wait in a queue, the current word is
  // emitted one bit per enabled edge, and gap marks the end of a burst.
  logic [W-1:0] wordQ[$];
  logic [W-1:0] curWord;
  int           bitIdx;
  bit           shifting;
  bit           armed;
  int           checkCnt;
  int           passCnt;
  int           lastSeq;
  logic [63:0]  capA;
  logic [63:0]  capB;
  int           gapsA;
  int           gapsB;
  int           validCntB;
  int           gapMarkA;
  int           gapMarkB;
  int           validMarkB;

  initial begin
    curWord = '0; bitIdx = 0; shifting = 0; armed = 0;
    checkCnt = 0; passCnt = 0; lastSeq = 0;
    capA = '0; capB = '0; gapsA = 0; gapsB = 0; validCntB = 0;
    gapMarkA = 0; gapMarkB = 0; validMarkB = 0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  always @(posedge clk) begin
    logic         sRst, sEn, sVal, readyBefore, newBit, expGap, expReady, expBusy;
    logic [W-1:0] sData;
    logic         expA, expB;
    sRst = rst; sEn = serEn; sVal = inValid; sData = inData;
    #1;
    newBit = 1'b0;
    expGap = 1'b0;
    if (sRst) begin
      armed = 1;
      wordQ.delete();
      shifting = 0;
      bitIdx = 0;
    end else begin
      readyBefore = (wordQ.size() == 0);
      if (sEn) begin
        if (shifting && bitIdx < W - 1) begin
          bitIdx++;
          newBit = 1'b1;
        end else if (wordQ.size() > 0) begin
          curWord = wordQ.pop_front();
          bitIdx = 0;
          shifting = 1;
          newBit = 1'b1;
        end else begin
          expGap = shifting;
          shifting = 0;
        end
      end
      if (sVal && readyBefore) wordQ.push_back(sData);
    end

    if (armed) begin
      expReady = (wordQ.size() == 0);
      expBusy  = shifting || !expReady;
      expA = shifting ? curWord[W-1-bitIdx] : 1'b0;
      expB = shifting ? curWord[bitIdx] : 1'b1;
      checkOutput("A.dout_valid", 64'(ifA.dout_valid), 64'(shifting));
      checkOutput("A.dout",       64'(ifA.dout),       64'(expA));
      checkOutput("A.gap",        64'(ifA.gap),        64'(expGap));
      checkOutput("A.in_ready",   64'(ifA.in_ready),   64'(expReady));
      checkOutput("A.busy",       64'(ifA.busy),       64'(expBusy));
      checkOutput("B.dout_valid", 64'(ifB.dout_valid), 64'(shifting));
      checkOutput("B.dout",       64'(ifB.dout),       64'(expB));
      checkOutput("B.gap",        64'(ifB.gap),        64'(expGap));
      checkOutput("B.in_ready",   64'(ifB.in_ready),   64'(expReady));
      checkOutput("B.busy",       64'(ifB.busy),       64'(expBusy));
      if (newBit) begin
        capA = {capA[62:0], ifA.dout};
        capB = {capB[62:0], ifB.dout};
      end
      if (ifA.gap === 1'b1) gapsA++;
      if (ifB.gap === 1'b1) gapsB++;
      if (ifB.dout_valid === 1'b1) validCntB++;
    end

    // Directed end-of-scenario checks requested by the stimulus process.
    if (reqSeq != lastSeq) begin
      lastSeq = reqSeq;
      case (reqKind)
        0: begin gapMarkA = gapsA; gapMarkB = gapsB; validMarkB = validCntB; end
        1: begin
          checkOutput("a5_stream", 64'(capA[7:0]), 64'h00A5);
          checkOutput("a5_gaps",   64'(gapsA - gapMarkA), 64'd1);
        end
        2: begin
          checkOutput("b2b_stream", 64'(capA[15:0]), 64'hAA55);
          checkOutput("b2b_gaps",   64'(gapsA - gapMarkA), 64'd1);
        end
        3: begin
          checkOutput("lsb_stream", 64'(capB[7:0]), 64'h0080);
          checkOutput("lsb_valid_cycles", 64'(validCntB - validMarkB), 64'd16);
          checkOutput("lsb_gaps", 64'(gapsB - gapMarkB), 64'd1);
        end
        default: checkOutput("wait_timeout", 64'(reqKind), 64'd0);
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    if (enMode == 1) serEn = ~serEn;
    else if (enMode == 2) serEn = 1'($urandom_range(0, 1));
    else serEn = 1'b1;
  endtask

  task automatic request(input int kind);
    reqKind = kind;
    reqSeq++;
    tick();
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input bit scramble);
    bit done;
    done = 0;
    inValid = 1'b1;
    inData = data;
    for (int i = 0; i < 200 && !done; i++) begin
      if (ifA.in_ready === 1'b1) done = 1;
      tick();
      if (!done && scramble) inData = W'($urandom);
    end
    inValid = 1'b0;
    if (!done) request(9);
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit drained;
    rst = 1'b1; inValid = 1'b0; inData = '0; serEn = 1'b1; enMode = 0;
    reqKind = 0; reqSeq = 0;
    @(negedge clk);
    idleTicks(2);
    rst = 1'b0;
    idleTicks(4);

    $display("[TB] single word A5");
    request(0);
    applyStimulus(8'hA5, 0);
    idleTicks(12);
    request(1);

    $display("[TB] back-to-back AA 55");
    request(0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'h55, 0);
    idleTicks(20);
    request(2);

    $display("[TB] LSB-first throttled 01");
    enMode = 1;
    request(0);
    applyStimulus(8'h01, 0);
    idleTicks(24);
    request(3);
    enMode = 0;
    idleTicks(2);

    $display("[TB] backpressure with stalled third word");
    applyStimulus(W'($urandom), 0);
    applyStimulus(W'($urandom), 0);
    applyStimulus(W'($urandom), 1);
    idleTicks(20);

    $display("[TB] reset mid-word");
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h3C, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idleTicks(3);
    applyStimulus(8'hC3, 0);
    idleTicks(12);

    $display("[TB] randomized words and enables");
    enMode = 2;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(W'($urandom), bit'($urandom_range(0, 1)));
      idleTicks($urandom_range(0, 3));
    end
    enMode = 0;
    drained = 0;
    for (int i = 0; i < 400 && !drained; i++) begin
      tick();
      if (ifA.busy === 1'b0 && ifB.busy === 1'b0) drained = 1;
    end
    if (!drained) request(8);
    idleTicks(3);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
